// File: rtl/fork_launch.sv
`default_nettype none
// ============================================================================
//  Module   : fork_launch
//  Purpose  : Per-core launch sequencer between the fork stage and the cores.
//             Each core runs an independent IDLE -> LOAD -> START -> RUN
//             sequence: a valid context is captured in IDLE, acknowledged
//             upstream in LOAD, loaded into the core in START, and the thread
//             runs until the core retires a JOIN opcode.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NCORES        number of cores served (2..16)
//    JOIN          opcode (ins_wb[15:12]) that retires a thread
//  Ports
//    clk           clock, rising edge
//    rst_n         asynchronous active-low reset
//    core_ens_in   [NCORES]     per-core enables from the fork stage
//    fork_cxt_in   [NCORES*33]  per-slice {valid, ptr[15:0], pc[15:0]}
//    ins_vld       [NCORES]     core i retired an instruction
//    ins_wb        [NCORES*16]  retired instruction of core i
//    core_ens_out  [NCORES]     core busy (LOAD/START/RUN)
//    fork_ack      [NCORES]     one-cycle pulse clearing slice i upstream
//    core_start    [NCORES]     one-cycle pulse loading pc/ptr into core i
//    core_pc       [NCORES*16]  captured start pc per core
//    core_ptr      [NCORES*16]  captured start ptr per core
//    all_idle                   every core is IDLE
//    active_cnt    [5]          live thread count (only with the macro)
//  Build option
//    FORK_LAUNCH_ACTIVE_CNT_EN  adds the active_cnt output and its counter
// ============================================================================
module fork_launch #(
  parameter int         NCORES = 4,
  parameter logic [3:0] JOIN   = 4'h8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCORES-1:0]    core_ens_in,
  input  logic [NCORES*33-1:0] fork_cxt_in,
  input  logic [NCORES-1:0]    ins_vld,
  input  logic [NCORES*16-1:0] ins_wb,
  output logic [NCORES-1:0]    core_ens_out,
  output logic [NCORES-1:0]    fork_ack,
  output logic [NCORES-1:0]    core_start,
  output logic [NCORES*16-1:0] core_pc,
  output logic [NCORES*16-1:0] core_ptr,
  output logic                 all_idle
`ifdef FORK_LAUNCH_ACTIVE_CNT_EN
  ,
  output logic [4:0]           active_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  state_t               state_q [NCORES];
  state_t               state_d [NCORES];
  logic [NCORES*16-1:0] pc_q, pc_d, ptr_q, ptr_d;
  logic [NCORES-1:0]    fork_ack_q, fork_ack_d;
  logic [NCORES-1:0]    core_start_q, core_start_d;
  logic [NCORES-1:0]    core_ens_q, core_ens_d;
  logic                 all_idle_q, all_idle_d;
  logic [NCORES-1:0]    launch;   // IDLE -> LOAD this cycle
  logic [NCORES-1:0]    retire;   // RUN -> IDLE this cycle

  // Only the opcode field of the retired instruction matters here.
  logic [NCORES*12-1:0] wb_unused;
  for (genvar g = 0; g < NCORES; g++) begin : g_wb_unused
    assign wb_unused[g*12 +: 12] = ins_wb[g*16 +: 12];
  end

  // Next-state logic. Outputs are registered from the next state so the
  // pulses line up with the state they belong to (ack in LOAD, start in START).
  always_comb begin
    all_idle_d = 1'b1;
    pc_d       = pc_q;
    ptr_d      = ptr_q;
    launch     = '0;
    retire     = '0;
    fork_ack_d   = '0;
    core_start_d = '0;
    core_ens_d   = '0;
    for (int i = 0; i < NCORES; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (core_ens_in[i] && fork_cxt_in[33*i+32]) begin
            state_d[i]       = ST_LOAD;
            launch[i]        = 1'b1;
            pc_d[16*i +: 16]  = fork_cxt_in[33*i    +: 16];
            ptr_d[16*i +: 16] = fork_cxt_in[33*i+16 +: 16];
          end
        end
        ST_LOAD:  state_d[i] = ST_START;
        ST_START: state_d[i] = ST_RUN;
        ST_RUN: begin
          // The slice valid bit is not looked at here, so a JOIN coinciding
          // with a new context retires first; capture happens from IDLE later.
          if (ins_vld[i] && (ins_wb[16*i+12 +: 4] == JOIN)) begin
            state_d[i] = ST_IDLE;
            retire[i]  = 1'b1;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
      fork_ack_d[i]   = (state_d[i] == ST_LOAD);
      core_start_d[i] = (state_d[i] == ST_START);
      core_ens_d[i]   = (state_d[i] != ST_IDLE);
      if (state_d[i] != ST_IDLE) all_idle_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Core 0 comes out of reset running the boot thread.
      for (int i = 0; i < NCORES; i++) begin
        if (i == 0) state_q[i] <= ST_RUN;
        else        state_q[i] <= ST_IDLE;
      end
      pc_q         <= '0;
      ptr_q        <= '0;
      fork_ack_q   <= '0;
      core_start_q <= '0;
      core_ens_q   <= NCORES'(1);
      all_idle_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NCORES; i++) state_q[i] <= state_d[i];
      pc_q         <= pc_d;
      ptr_q        <= ptr_d;
      fork_ack_q   <= fork_ack_d;
      core_start_q <= core_start_d;
      core_ens_q   <= core_ens_d;
      all_idle_q   <= all_idle_d;
    end
  end

  assign core_ens_out = core_ens_q;
  assign fork_ack     = fork_ack_q;
  assign core_start   = core_start_q;
  assign core_pc      = pc_q;
  assign core_ptr     = ptr_q;
  assign all_idle     = all_idle_q;

`ifdef FORK_LAUNCH_ACTIVE_CNT_EN
  logic [4:0] active_cnt_q, active_cnt_d;
  int         cnt_sum;

  // Net change is applied in one step and clamped to 0..NCORES.
  always_comb begin
    cnt_sum = int'(active_cnt_q);
    for (int i = 0; i < NCORES; i++) begin
      cnt_sum = cnt_sum + int'(launch[i]) - int'(retire[i]);
    end
    if (cnt_sum < 0)            cnt_sum = 0;
    else if (cnt_sum > NCORES)  cnt_sum = NCORES;
    active_cnt_d = 5'(cnt_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) active_cnt_q <= 5'd1;
    else        active_cnt_q <= active_cnt_d;
  end

  assign active_cnt = active_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fork_launch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fork_launch
//  Purpose  : Directed self-checking bench for fork_launch (NCORES = 4).
//             Expected launches are queued when a context is offered and
//             checked against core_start / core_pc / core_ptr when the pulse
//             appears. Honours FORK_LAUNCH_ACTIVE_CNT_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fork_launch;
  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]    core_ens_in;
  logic [N*33-1:0] fork_cxt_in;
  logic [N-1:0]    ins_vld;
  logic [N*16-1:0] ins_wb;
  logic [N-1:0]    core_ens_out;
  logic [N-1:0]    fork_ack;
  logic [N-1:0]    core_start;
  logic [N*16-1:0] core_pc;
  logic [N*16-1:0] core_ptr;
  logic            all_idle;
`ifdef FORK_LAUNCH_ACTIVE_CNT_EN
  logic [4:0]      active_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] core;
    logic [15:0] pc;
    logic [15:0] ptr;
  } exp_t;
  exp_t sb[$];

  fork_launch #(.NCORES(N), .JOIN(4'h8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_ens_in  (core_ens_in),
    .fork_cxt_in  (fork_cxt_in),
    .ins_vld      (ins_vld),
    .ins_wb       (ins_wb),
    .core_ens_out (core_ens_out),
    .fork_ack     (fork_ack),
    .core_start   (core_start),
    .core_pc      (core_pc),
    .core_ptr     (core_ptr),
    .all_idle     (all_idle)
`ifdef FORK_LAUNCH_ACTIVE_CNT_EN
    ,
    .active_cnt   (active_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int i, input logic v, input logic [15:0] ptr, input logic [15:0] pc);
    fork_cxt_in[33*i +: 33] = {v, ptr, pc};
  endtask

  task automatic offer(input int i, input logic [15:0] ptr, input logic [15:0] pc);
    exp_t e;
    set_slice(i, 1'b1, ptr, pc);
    core_ens_in[i] = 1'b1;
    e.core = 32'(i);
    e.pc   = pc;
    e.ptr  = ptr;
    sb.push_back(e);
  endtask

  task automatic join_core(input int i, input logic [15:0] ins);
    ins_vld[i]        = 1'b1;
    ins_wb[16*i +: 16] = ins;
  endtask

  task automatic clear_inputs();
    core_ens_in = '0;
    fork_cxt_in = '0;
    ins_vld     = '0;
    ins_wb      = '0;
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] exp);
`ifdef FORK_LAUNCH_ACTIVE_CNT_EN
    check(tag, 32'(active_cnt), exp);
`else
    check(tag, 32'(all_idle), (exp == 0) ? 32'h1 : 32'h0);
`endif
  endtask

  // Scoreboard: every core_start pulse must match the oldest queued launch.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (core_start[i]) begin
          if (sb.size() == 0) begin
            check("unexpected_start", 32'(i), 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_core", 32'(i), e.core);
            check("sb_pc",   32'(core_pc[16*i +: 16]),  32'(e.pc));
            check("sb_ptr",  32'(core_ptr[16*i +: 16]), 32'(e.ptr));
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    check("rst_ens",   32'(core_ens_out), 32'h1);
    check("rst_ack",   32'(fork_ack),     32'h0);
    check("rst_start", 32'(core_start),   32'h0);
    check("rst_idle",  32'(all_idle),     32'h0);
    check("rst_pc",    32'(core_pc),      32'h0);
    check("rst_ptr",   32'(core_ptr),     32'h0);
    check_cnt("rst_cnt", 32'd1);

    step();
    rst_n = 1'b1;
    step();
    check("rel_ens",   32'(core_ens_out), 32'h1);
    check("rel_pulse", 32'({fork_ack, core_start}), 32'h0);
    check("rel_idle",  32'(all_idle),     32'h0);

    // Launch on core 2
    offer(2, 16'h0040, 16'h0123);
    step();
    check("l2_ack",   32'(fork_ack),     32'h4);
    check("l2_start", 32'(core_start),   32'h0);
    check("l2_ens",   32'(core_ens_out), 32'h5);
    clear_inputs();
    step();
    check("l2_ack_off", 32'(fork_ack),   32'h0);
    check("l2_start1",  32'(core_start), 32'h4);
    check("l2_pc",  32'(core_pc[32 +: 16]),  32'h0123);
    check("l2_ptr", 32'(core_ptr[32 +: 16]), 32'h0040);
    step();
    check("l2_start0", 32'(core_start),   32'h0);
    check("l2_run",    32'(core_ens_out), 32'h5);
    check_cnt("l2_cnt", 32'd2);

    // Core 2 retires JOIN
    join_core(2, 16'h8000);
    step();
    clear_inputs();
    check("j2_ens", 32'(core_ens_out), 32'h1);
    check_cnt("j2_cnt", 32'd1);
    check("j2_pc_hold", 32'(core_pc[32 +: 16]), 32'h0123);

    // JOIN from an idle core and a non-JOIN from a running core are ignored
    join_core(0, 16'h7FFF);
    join_core(1, 16'h8000);
    step();
    clear_inputs();
    check("ign_ens", 32'(core_ens_out), 32'h1);
    check("ign_ack", 32'(fork_ack),     32'h0);

    // Launch core 1, then JOIN coinciding with a new valid context
    offer(1, 16'h0011, 16'h0022);
    step();
    check("l1_ack", 32'(fork_ack), 32'h2);
    clear_inputs();
    step();
    step();
    check("l1_run", 32'(core_ens_out), 32'h3);
    join_core(1, 16'h8ABC);
    set_slice(1, 1'b1, 16'h0033, 16'h0044);
    core_ens_in[1] = 1'b1;
    step();
    check("co_ens", 32'(core_ens_out), 32'h1);
    check("co_ack", 32'(fork_ack),     32'h0);
    check("co_pc_hold", 32'(core_pc[16 +: 16]), 32'h0022);
    ins_vld = '0;
    offer(1, 16'h0033, 16'h0044);
    step();
    check("co_cap_ack", 32'(fork_ack),     32'h2);
    check("co_cap_ens", 32'(core_ens_out), 32'h3);
    check("co_cap_pc",  32'(core_pc[16 +: 16]), 32'h0044);
    clear_inputs();
    step();
    step();
    join_core(1, 16'h8000);
    step();
    clear_inputs();
    check("j1_ens", 32'(core_ens_out), 32'h1);
    check_cnt("j1_cnt", 32'd1);

    // Cores 1 and 3 launch while core 0 joins
    offer(1, 16'h0101, 16'h0202);
    offer(3, 16'h0303, 16'h0404);
    join_core(0, 16'h8000);
    step();
    clear_inputs();
    check("m_ens", 32'(core_ens_out), 32'hA);
    check("m_ack", 32'(fork_ack),     32'hA);
    check_cnt("m_cnt", 32'd2);
    step();
    check("m_start", 32'(core_start), 32'hA);
    step();
    join_core(1, 16'h8000);
    join_core(3, 16'h8001);
    step();
    clear_inputs();
    check("m_allidle", 32'(all_idle),     32'h1);
    check("m_ens0",    32'(core_ens_out), 32'h0);
    check_cnt("m_cnt0", 32'd0);

    // Reset while core 3 is in LOAD aborts the launch
    set_slice(3, 1'b1, 16'h0505, 16'h0606);
    core_ens_in[3] = 1'b1;
    step();
    check("a_ack", 32'(fork_ack), 32'h8);
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check("a_ens",   32'(core_ens_out), 32'h1);
    check("a_pulse", 32'({fork_ack, core_start}), 32'h0);
    check("a_pc",    32'(core_pc[48 +: 16]), 32'h0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("a_nostart", 32'(core_start), 32'h0);
      check("a_noack",   32'(fork_ack),   32'h0);
    end
    check("a_ens_end", 32'(core_ens_out), 32'h1);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
